// File: rtl/cpu_boot_harness_pkg.sv
// Shared definitions for the CPU boot harness.
// Holds the controller state encoding, the default halt word and the byte
// stride between consecutive memory words.
package cpu_harness_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;
    localparam int unsigned WORD_STRIDE        = 4;

endpackage

// File: rtl/cpu_boot_harness_if.sv
// Load-stream and memory-write bundle for the CPU boot harness.
//   in_valid / in_ready / in_data / in_last : program image stream (host -> harness)
//   mem_we / mem_addr / mem_wdata           : memory write port (harness -> memory)
// Modports:
//   slave  : harness view (consumes the stream, drives the memory port)
//   master : host/test view (produces the stream, observes the memory port)
interface cpu_boot_harness_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cpu_boot_harness_watchdog.sv
// harness_watchdog: saturating 32-bit run-cycle counter with expiry compare.
// Ports:
//   clock, reset : clock (rising edge), asynchronous active-high reset
//   clear        : zero the counter (has priority over enable)
//   enable       : count this cycle
//   count        : cycles counted so far
//   expire       : this enabled cycle brings the count to TIMEOUT_CYCLES or beyond
module harness_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic [31:0] count,
    output logic        expire
);
    logic [31:0] count_q, count_d, count_inc;

    assign count_inc = (count_q == '1) ? count_q : count_q + 32'd1;

    // Expiry looks at the post-increment value so the cycle that reaches the
    // limit is itself counted.
    assign expire = enable & (count_inc >= 32'(TIMEOUT_CYCLES));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/cpu_boot_harness.sv
// cpu_boot_harness: boot/run controller for the MIPS CPU.
// Streams a program image into memory, releases the CPU from reset, then
// watches the fetch stream for the halt word under a cycle watchdog.
// Ports:
//   clock, reset   : clock (rising edge), asynchronous active-high reset
//   start          : begin a load (honoured in IDLE, DONE, TIMEOUT)
//   bus (slave)    : load stream in, memory write port out
//   cpu_reset      : CPU reset, high everywhere except RUN
//   cpu_pc         : CPU fetch address, captured on halt
//   cpu_instr      : CPU fetched word, compared against HALT_INSTR
//   busy           : LOAD or RUN
//   done, timed_out, overflow : sticky status, cleared on start
//   words_loaded   : words written this load
//   cycle_count    : RUN cycles, saturating
//   halt_pc        : cpu_pc at the halt cycle
//   checksum       : running sum of written words
// Build option: CPU_BOOT_HARNESS_CHECKSUM_EN enables the checksum adder;
// without it the checksum port is tied to zero.
module cpu_boot_harness
    import cpu_harness_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           MEM_DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR     = DEFAULT_HALT_INSTR,
    parameter int unsigned           TIMEOUT_CYCLES = 1000,
    localparam int unsigned          WL_W           = $clog2(MEM_DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    cpu_boot_harness_if.slave     bus,
    output logic                  cpu_reset,
    input  logic [ADDR_WIDTH-1:0] cpu_pc,
    input  logic [DATA_WIDTH-1:0] cpu_instr,
    output logic                  busy,
    output logic                  done,
    output logic                  timed_out,
    output logic                  overflow,
    output logic [WL_W-1:0]       words_loaded,
    output logic [31:0]           cycle_count,
    output logic [ADDR_WIDTH-1:0] halt_pc,
    output logic [DATA_WIDTH-1:0] checksum
);
    state_e                state_q, state_d;
    logic                  drain_q, drain_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  done_q, done_d;
    logic                  timed_out_q, timed_out_d;
    logic                  overflow_q, overflow_d;
    logic [WL_W-1:0]       words_loaded_q, words_loaded_d;
    logic [ADDR_WIDTH-1:0] halt_pc_q, halt_pc_d;

    logic        in_ready;
    logic        xfer;
    logic        full;
    logic        word_accept;
    logic        start_ok;
    logic        halt_hit;
    logic        wd_clear;
    logic        wd_en;
    logic        wd_expire;
    logic [31:0] wd_count;

    // After the in_last transfer the harness spends one more LOAD cycle with
    // the stream closed so the final write is visible before the CPU leaves
    // reset; drain_q marks that cycle.
    assign in_ready    = (state_q == ST_LOAD) & ~drain_q;
    assign xfer        = bus.in_valid & in_ready;
    assign full        = (words_loaded_q == WL_W'(MEM_DEPTH));
    assign word_accept = xfer & ~full;
    assign start_ok    = start & ((state_q == ST_IDLE) | (state_q == ST_DONE) |
                                  (state_q == ST_TIMEOUT));
    assign halt_hit    = (cpu_instr == HALT_INSTR);
    assign wd_clear    = start_ok;
    assign wd_en       = (state_q == ST_RUN);

    harness_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock (clock),
        .reset (reset),
        .clear (wd_clear),
        .enable(wd_en),
        .count (wd_count),
        .expire(wd_expire)
    );

    always_comb begin
        state_d        = state_q;
        drain_d        = drain_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        done_d         = done_q;
        timed_out_d    = timed_out_q;
        overflow_d     = overflow_q;
        words_loaded_d = words_loaded_q;
        halt_pc_d      = halt_pc_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start_ok) begin
                    done_d         = 1'b0;
                    timed_out_d    = 1'b0;
                    overflow_d     = 1'b0;
                    words_loaded_d = '0;
                    halt_pc_d      = '0;
                    mem_addr_d     = BASE_ADDR;
                    drain_d        = 1'b0;
                    state_d        = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = ST_RUN;
                end else if (xfer) begin
                    if (full) begin
                        // Word beyond capacity: dropped, load aborted.
                        overflow_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        mem_we_d       = 1'b1;
                        mem_wdata_d    = bus.in_data;
                        mem_addr_d     = BASE_ADDR + (ADDR_WIDTH'(words_loaded_q) *
                                                      ADDR_WIDTH'(WORD_STRIDE));
                        words_loaded_d = words_loaded_q + WL_W'(1);
                        drain_d        = bus.in_last;
                    end
                end
            end
            ST_RUN: begin
                // Halt is tested first so it wins over a coincident expiry.
                if (halt_hit) begin
                    halt_pc_d = cpu_pc;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else if (wd_expire) begin
                    timed_out_d = 1'b1;
                    state_d     = ST_TIMEOUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            drain_q        <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= BASE_ADDR;
            mem_wdata_q    <= '0;
            done_q         <= 1'b0;
            timed_out_q    <= 1'b0;
            overflow_q     <= 1'b0;
            words_loaded_q <= '0;
            halt_pc_q      <= '0;
        end else begin
            state_q        <= state_d;
            drain_q        <= drain_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            done_q         <= done_d;
            timed_out_q    <= timed_out_d;
            overflow_q     <= overflow_d;
            words_loaded_q <= words_loaded_d;
            halt_pc_q      <= halt_pc_d;
        end
    end

`ifdef CPU_BOOT_HARNESS_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_ok) begin
            checksum_d = '0;
        end else if (word_accept) begin
            checksum_d = checksum_q + bus.in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_reset     = (state_q != ST_RUN);
    assign busy          = (state_q == ST_LOAD) | (state_q == ST_RUN);
    assign done          = done_q;
    assign timed_out     = timed_out_q;
    assign overflow      = overflow_q;
    assign words_loaded  = words_loaded_q;
    assign cycle_count   = wd_count;
    assign halt_pc       = halt_pc_q;
endmodule

// File: doc/cpu_boot_harness.md
Name: cpu_boot_harness

Overview:
- Synthesisable boot/run controller for the MIPS CPU: streams a program image into instruction/data memory over a valid/ready interface, then releases the CPU from reset.
- Watches the fetch stream for a halt word and counts run cycles, with a timeout watchdog.
- Sits between the test/host side and the CPU top, driving the memory write port and the CPU reset.

Parameters:
- DATA_WIDTH, 32, memory word width; also the width of in_data and cpu_instr.
- ADDR_WIDTH, 32, byte-address width of mem_addr and cpu_pc.
- MEM_DEPTH, 256, memory capacity in words; the maximum load length.
- BASE_ADDR, 0, byte address of the first loaded word.
- HALT_INSTR, 32'hFFFFFFFF, fetched word that signals program end.
- TIMEOUT_CYCLES, 1000, maximum run cycles before abort; must be ≥1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured in IDLE, DONE and TIMEOUT only.
- in_valid  in  1  load word valid.
- in_ready  out  1  harness accepts a load word.
- in_data  in  DATA_WIDTH  load word.
- in_last  in  1  marks the final load word.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory byte address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- cpu_reset  out  1  reset to CPU, active-high.
- cpu_pc  in  ADDR_WIDTH  CPU fetch address (monitor only).
- cpu_instr  in  DATA_WIDTH  CPU fetched instruction.
- busy  out  1  high in LOAD or RUN.
- done  out  1  sticky: halt seen.
- timed_out  out  1  sticky: watchdog expired.
- overflow  out  1  sticky: load exceeded MEM_DEPTH.
- words_loaded  out  clog2(MEM_DEPTH)+1  count of words written.
- cycle_count  out  32  CPU run cycles.
- halt_pc  out  ADDR_WIDTH  cpu_pc captured at halt.
- checksum  out  DATA_WIDTH  load checksum; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - cpu_reset = 1.
  - in_ready = 0, mem_we = 0, mem_addr = BASE_ADDR, mem_wdata = 0.
  - busy = done = timed_out = overflow = 0.
  - words_loaded = cycle_count = halt_pc = checksum = 0.
- IDLE:
  - cpu_reset = 1.
  - On start: clear done, timed_out, overflow, words_loaded, cycle_count, halt_pc and checksum; set mem_addr = BASE_ADDR; go to LOAD.
- LOAD:
  - in_ready = 1; cpu_reset = 1.
  - Handshake: a transfer occurs on a cycle with in_valid & in_ready. On the next cycle, mem_we = 1 (registered, 1-cycle latency) and mem_wdata = in_data.
  - mem_addr advances by 4 after each write; words_loaded increments.
  - in_last on a transfer: the last write is issued, then go to RUN on the following cycle.
  - A transfer when words_loaded == MEM_DEPTH: the word is dropped (no write), overflow = 1, go to DONE with done = 0.
  - in_valid held low: stay in LOAD indefinitely; no timeout applies.
- RUN:
  - cpu_reset = 0 from the first RUN cycle.
  - cycle_count increments every RUN cycle, saturating at 2^32-1.
  - cpu_instr == HALT_INSTR: capture halt_pc = cpu_pc, set done = 1, go to DONE. cycle_count includes the halt cycle.
  - cycle_count reaching TIMEOUT_CYCLES: set timed_out = 1, go to TIMEOUT.
  - Halt and timeout on the same cycle: halt wins; done = 1, timed_out = 0.
- DONE / TIMEOUT:
  - cpu_reset = 1; status outputs hold.
  - start restarts the sequence as from IDLE.
- start during LOAD or RUN is ignored.
- in_ready is 0 in every state except LOAD.
- Reset asserted mid-load or mid-run: immediate abort to reset values; any partial memory contents are not cleared.
- busy = (state == LOAD) | (state == RUN).
- Addresses wrap modulo 2^ADDR_WIDTH.

Optional Feature:
- Macro: CPU_BOOT_HARNESS_CHECKSUM_EN.
- Defined: checksum = running sum of accepted load words, modulo 2^DATA_WIDTH. It is updated on each written word; overflow-dropped words are excluded. It is cleared on start and holds after LOAD.
- Undefined: the checksum port exists but is tied to 0, and no adder logic is present.

Decomposition:
- Shared package cpu_harness_pkg holds:
  - the state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3, TIMEOUT=4; 3 bits);
  - the default HALT_INSTR value;
  - the word stride constant (4).
- One natural sub-module: harness_watchdog, a saturating 32-bit cycle counter with a clear input, an enable input and an expiry compare against TIMEOUT_CYCLES.

Test Plan:
1. Basic load: reset, start, stream 3 words {20100009, 00000000, FFFFFFFF}, in_last on word 3 -> writes at addresses 0, 4, 8; words_loaded = 3; cpu_reset falls on the cycle after the last write.
2. Halt: in RUN, drive cpu_instr = FFFFFFFF at cycle 5 with cpu_pc = 8 -> done = 1, halt_pc = 8, cycle_count = 5, cpu_reset = 1.
3. Timeout: TIMEOUT_CYCLES = 10, never halt -> timed_out = 1 at cycle_count = 10, state TIMEOUT. A simultaneous halt at cycle 10 -> done = 1, timed_out = 0.
4. Overflow: MEM_DEPTH = 4, stream 5 words without in_last -> 4 writes; overflow = 1; the 5th word is not written; CPU never released.
5. Backpressure and reset: toggle in_valid randomly -> writes are contiguous in address order. Assert reset during RUN -> all outputs return to reset values asynchronously.
6. Checksum with macro defined: words 1, 2, FFFFFFFF -> checksum = 00000002. Macro undefined -> checksum = 0.
